// File: rtl/adder_seq.sv
// Multi-cycle chunked adder: adds two WIDTH-bit operands CHUNK bits per clock.
// Optional subtract mode is enabled by defining ADDER_SEQ_SUB_EN.
module adder_seq #(
    parameter int WIDTH = 6,
    parameter int CHUNK = 2
) (
    input  logic             i_w_clk,
    input  logic             i_w_reset,
    input  logic             i_w_start,
    input  logic [WIDTH-1:0] i_w_a,
    input  logic [WIDTH-1:0] i_w_b,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             i_w_sub,
`endif
    output logic             o_w_busy,
    output logic             o_w_done,
    output logic [WIDTH:0]   o_w_s
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int EXT    = NCHUNK * CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [EXT-1:0] MASK = EXT'({CHUNK{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [EXT-1:0]  r_a;
    logic [EXT-1:0]  r_b;
    logic [EXT-1:0]  r_sum;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;

    logic [31:0]     w_sh;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic [CHUNK:0]  w_csum;
    logic [EXT-1:0]  w_sum_next;
    logic [EXT:0]    w_ext;
    logic [WIDTH-1:0] w_b_in;
    logic            w_c0;
    logic            w_last;

    // Subtraction is A + ~B + 1; B is inverted over WIDTH bits only so the
    // zero-extended top chunk still yields the true carry at bit WIDTH.
`ifdef ADDER_SEQ_SUB_EN
    assign w_b_in = i_w_sub ? ~i_w_b : i_w_b;
    assign w_c0   = i_w_sub;
`else
    assign w_b_in = i_w_b;
    assign w_c0   = 1'b0;
`endif

    assign w_sh       = {{(32-IDXW){1'b0}}, r_idx} * 32'(CHUNK);
    assign w_ca       = CHUNK'(r_a >> w_sh);
    assign w_cb       = CHUNK'(r_b >> w_sh);
    assign w_csum     = {1'b0, w_ca} + {1'b0, w_cb} + (CHUNK+1)'(r_carry);
    assign w_sum_next = (r_sum & ~(MASK << w_sh)) | (EXT'(w_csum[CHUNK-1:0]) << w_sh);
    assign w_ext      = {w_csum[CHUNK], w_sum_next};
    assign w_last     = (r_idx == IDXW'(NCHUNK - 1));

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            o_w_busy <= 1'b0;
            o_w_done <= 1'b0;
            o_w_s    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    o_w_done <= 1'b0;
                    if (i_w_start) begin
                        r_a      <= EXT'(i_w_a);
                        r_b      <= EXT'(w_b_in);
                        r_sum    <= '0;
                        r_carry  <= w_c0;
                        r_idx    <= '0;
                        o_w_busy <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        o_w_busy <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_csum[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        o_w_s    <= (WIDTH+1)'(w_ext);
                        o_w_busy <= 1'b0;
                        o_w_done <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    o_w_busy <= 1'b0;
                    o_w_done <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
